// File: rtl/icache_controller_if.sv
// icache_controller_if: CPU fetch, cache storage, next-level memory and counter signals of the icache controller
interface icache_controller_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int COUNT_WIDTH = 16
);
  logic cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic cpu_ready;
  logic cpu_valid;
  logic [WORD_WIDTH-1:0] cpu_data;
  logic cs_read;
  logic cs_write;
  logic [ADDR_WIDTH-1:0] cs_address;
  logic [WORD_WIDTH-1:0] cs_write_block;
  logic [WORD_WIDTH-1:0] cs_read_data;
  logic cs_hit;
  logic mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_valid;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic [COUNT_WIDTH-1:0] hit_count;
  logic [COUNT_WIDTH-1:0] miss_count;
  modport master (
    input cpu_req, cpu_addr, cs_read_data, cs_hit, mem_valid, mem_rdata,
    output cpu_ready, cpu_valid, cpu_data, cs_read, cs_write, cs_address, cs_write_block,
    output mem_req, mem_addr, hit_count, miss_count
  );
  modport slave (
    output cpu_req, cpu_addr, cs_read_data, cs_hit, mem_valid, mem_rdata,
    input cpu_ready, cpu_valid, cpu_data, cs_read, cs_write, cs_address, cs_write_block,
    input mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_controller.sv
// icache_controller: direct-mapped instruction cache control FSM with miss fill forwarding and saturating hit/miss counters
module icache_controller #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  icache_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_WAIT, FILL} state_t;
  localparam logic [COUNT_WIDTH-1:0] cnt_max = '1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] fill_q, fill_d, data_q, data_d;
  logic [COUNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d;
  // state and datapath registers; reset abandons any lookup or fill in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      mem_addr_q <= '0;
      fill_q <= '0;
      data_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      mem_addr_q <= mem_addr_d;
      fill_q <= fill_d;
      data_q <= data_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  // next state, one-state strobes, and the held copies of address/data outputs
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    mem_addr_d = mem_addr_q;
    fill_d = fill_q;
    data_d = data_q;
    hit_d = hit_q;
    miss_d = miss_q;
    bus.cpu_ready = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_data = data_q;
    bus.cs_read = 1'b0;
    bus.cs_write = 1'b0;
    bus.mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cpu_ready = reset_n;
        if (bus.cpu_req) begin
          addr_d = bus.cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.cs_read = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (bus.cs_hit) begin
          bus.cpu_valid = 1'b1;
          bus.cpu_data = bus.cs_read_data;
          data_d = bus.cs_read_data;
          hit_d = (hit_q == cnt_max) ? hit_q : hit_q + 1'b1;
          state_d = IDLE;
        end else begin
          miss_d = (miss_q == cnt_max) ? miss_q : miss_q + 1'b1;
          mem_addr_d = addr_q;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        bus.mem_req = 1'b1;
        if (bus.mem_valid) begin
          fill_d = bus.mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.cs_write = 1'b1;
        bus.cpu_valid = 1'b1;
        bus.cpu_data = fill_q;
        data_d = fill_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.cs_address = addr_q;
  assign bus.cs_write_block = fill_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.hit_count = hit_q;
  assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: transaction-level model check of the icache controller with storage and memory responders
module tb_icache_controller;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int resp_lat = 1, mk = 0;
  bit busy = 0, mhit = 0;
  int t = 0, vc = 0, mn = 0, lat = 0, acc_cyc = 0, val_cyc = 0, mreq_cnt = 0, n_acc = 0, n_val = 0, hcnt = 0, mcnt = 0;
  logic [31:0] ma = '0, mdata = '0, last_data = '0;
  bit ref_v [256];
  logic [31:0] ref_a [256];
  logic [31:0] ref_d [256];
  logic [255:0] st_v;
  logic [31:0] st_a [256];
  logic [31:0] st_d [256];
  bit er, erd, ev, ew, em;
  int b, v0, a0;
  icache_controller_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .COUNT_WIDTH(CW)) bus ();
  icache_controller #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .COUNT_WIDTH(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] memword(input logic [31:0] a);
    return a == 32'h104 ? 32'hDEADBEEF : a == 32'h0010_0104 ? 32'h1234_5678 : a ^ 32'h5A5A_5A5A;
  endfunction
  function automatic int ix(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // direct-mapped storage with registered read outputs, cleared by reset
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st_v <= '0;
      bus.cs_hit <= 1'b0;
      bus.cs_read_data <= '0;
    end else begin
      if (bus.cs_read) begin
        bus.cs_hit <= st_v[ix(bus.cs_address)] && st_a[ix(bus.cs_address)] == bus.cs_address;
        bus.cs_read_data <= st_d[ix(bus.cs_address)];
      end
      if (bus.cs_write) begin
        st_v[ix(bus.cs_address)] <= 1'b1;
        st_a[ix(bus.cs_address)] <= bus.cs_address;
        st_d[ix(bus.cs_address)] <= bus.cs_write_block;
      end
    end
  // memory answers in the resp_lat-th cycle of a request
  always @(posedge clk) begin
    #2;
    if (reset_n && bus.mem_req) begin
      mk = mk + 1;
      bus.mem_valid = (mk == resp_lat);
      bus.mem_rdata = memword(bus.mem_addr);
    end else begin
      mk = 0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = '0;
    end
  end
  // transaction model: acceptance at T, hit answers at T+2, miss at T+3+N
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_strobes", 64'({bus.cpu_ready, bus.cpu_valid, bus.cs_read, bus.cs_write, bus.mem_req}), 64'h0);
      chk("rst_cpu_data", 64'(bus.cpu_data), 64'h0);
      chk("rst_counts", 64'({bus.hit_count, bus.miss_count}), 64'h0);
      busy = 0;
      hcnt = 0;
      mcnt = 0;
      last_data = '0;
      for (int i = 0; i < 256; i++) ref_v[i] = 0;
    end else begin
      er = !busy;
      erd = busy && cyc == t + 1;
      ev = busy && cyc == vc;
      ew = ev && !mhit;
      em = busy && !mhit && cyc >= t + 3 && cyc <= t + 2 + mn;
      chk("cpu_ready", 64'(bus.cpu_ready), 64'(er));
      chk("cs_read", 64'(bus.cs_read), 64'(erd));
      chk("cpu_valid", 64'(bus.cpu_valid), 64'(ev));
      chk("cs_write", 64'(bus.cs_write), 64'(ew));
      chk("mem_req", 64'(bus.mem_req), 64'(em));
      if (em) chk("mem_addr", 64'(bus.mem_addr), 64'(ma));
      if (erd || ew) chk("cs_address", 64'(bus.cs_address), 64'(ma));
      if (ew) chk("cs_write_block", 64'(bus.cs_write_block), 64'(mdata));
      if (ev) last_data = mdata;
      chk("cpu_data", 64'(bus.cpu_data), 64'(last_data));
      chk("hit_count", 64'(bus.hit_count), 64'(hcnt));
      chk("miss_count", 64'(bus.miss_count), 64'(mcnt));
      if (bus.mem_req) mreq_cnt++;
      if (busy && cyc == t + 2) begin
        if (mhit) hcnt = (hcnt == CMAX) ? hcnt : hcnt + 1;
        else mcnt = (mcnt == CMAX) ? mcnt : mcnt + 1;
      end
      if (ev) begin
        if (!mhit) begin
          ref_v[ix(ma)] = 1;
          ref_a[ix(ma)] = ma;
          ref_d[ix(ma)] = mdata;
        end
        busy = 0;
        n_val++;
        val_cyc = cyc;
        lat = cyc - t;
      end
      if (er && bus.cpu_req) begin
        busy = 1;
        t = cyc;
        ma = bus.cpu_addr;
        mhit = ref_v[ix(ma)] && ref_a[ix(ma)] == ma;
        mn = resp_lat;
        mdata = mhit ? ref_d[ix(ma)] : memword(ma);
        vc = mhit ? cyc + 2 : cyc + 3 + mn;
        n_acc++;
        acc_cyc = cyc;
        mreq_cnt = 0;
      end
    end
  end
  task automatic fetch(input logic [31:0] a, input int l);
    int v, k;
    v = n_val;
    k = 0;
    resp_lat = l;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    while (n_val == v && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("fetch_done", 64'(n_val != v), 64'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("ready_after_por", 64'(bus.cpu_ready), 64'd1);
    resp_lat = 10;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h3000;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_mem_req", 64'(bus.mem_req), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_async_addrs", 64'({bus.mem_addr, bus.cs_address}), 64'h0);
    chk("rst_async_wblock", 64'(bus.cs_write_block), 64'h0);
    chk("rst_async_valid", 64'({bus.cpu_valid, bus.cs_write, bus.cpu_ready}), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("ready_after_rst", 64'(bus.cpu_ready), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    fetch(32'h104, 3);
    chk("cold_latency", 64'(lat), 64'd6);
    chk("cold_data", 64'(bus.cpu_data), 64'hDEADBEEF);
    chk("cold_mreq_cycles", 64'(mreq_cnt), 64'd3);
    chk("cold_miss_count", 64'(bus.miss_count), 64'd1);
    fetch(32'h104, 1);
    chk("hit_latency", 64'(lat), 64'd2);
    chk("hit_data", 64'(bus.cpu_data), 64'hDEADBEEF);
    chk("hit_no_mreq", 64'(mreq_cnt), 64'd0);
    chk("hit_count_1", 64'(bus.hit_count), 64'd1);
    fetch(32'h0010_0104, 1);
    chk("conflict_latency", 64'(lat), 64'd4);
    chk("conflict_data", 64'(bus.cpu_data), 64'h12345678);
    chk("conflict_miss_count", 64'(bus.miss_count), 64'd2);
    fetch(32'h104, 1);
    chk("remiss_latency", 64'(lat), 64'd4);
    chk("remiss_data", 64'(bus.cpu_data), 64'hDEADBEEF);
    chk("remiss_miss_count", 64'(bus.miss_count), 64'd3);
    v0 = n_val;
    a0 = n_acc;
    b = 0;
    resp_lat = 2;
    bus.cpu_req = 1'b1;
    while (n_acc < a0 + 2 && b < 60) begin
      bus.cpu_addr = 32'h2000 + 32'((cyc & 63) << 2);
      @(posedge clk);
      #1 b++;
    end
    bus.cpu_req = 1'b0;
    chk("busy_accepts", 64'(n_acc - a0), 64'd2);
    chk("busy_gap", 64'(acc_cyc - val_cyc), 64'd1);
    b = 0;
    while (n_val < v0 + 2 && b < 60) begin
      @(posedge clk);
      b++;
    end
    #1 chk("busy_done", 64'(n_val - v0), 64'd2);
    chk("busy_miss_count", 64'(bus.miss_count), 64'd5);
    for (int i = 0; i < 17; i++) fetch(32'h104, 1);
    chk("sat_hit_count", 64'(bus.hit_count), 64'd15);
    repeat (5) @(posedge clk);
    #1 chk("sat_hit_hold", 64'(bus.hit_count), 64'd15);
    chk("sat_miss_count", 64'(bus.miss_count), 64'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
